// File: rtl/fir_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fir_ctrl_pkg
// Shared constants and types for the FIR coefficient sequencer.
//   DEC_ADDR    : host address of the decimation shadow register
//   CHK_ADDR    : host address of the expected-checksum register (only mapped
//                 when FIR_COE_CHKSUM_EN is defined)
//   fir_state_e : sequencer FSM state encoding
// -----------------------------------------------------------------------------
package fir_ctrl_pkg;

  localparam logic [7:0] DEC_ADDR = 8'hFF;
  localparam logic [7:0] CHK_ADDR = 8'hFE;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    GAP    = 3'd2,
    LOAD   = 3'd3,
    DONE   = 3'd4
  } fir_state_e;

endpackage

// File: rtl/fir_coe_shadow.sv
// -----------------------------------------------------------------------------
// fir_coe_shadow
// Shadow store for the symmetric half of the FIR coefficient set.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears every entry)
//   wr_en     : write strobe (already qualified by the sequencer)
//   wr_addr   : entry index, 0..COE_NUM_HALF-1
//   wr_data   : coefficient value
//   rd_en     : load the read register from entry rd_addr
//   rd_addr   : entry index driven by the sequencer beat counter
//   rd_data   : registered read data; holds while rd_en is low
// -----------------------------------------------------------------------------
module fir_coe_shadow
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned COE_WDTH     = 29,
  parameter int unsigned COE_NUM_HALF = 26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [7:0]          wr_addr,
  input  logic [COE_WDTH-1:0] wr_data,
  input  logic                rd_en,
  input  logic [7:0]          rd_addr,
  output logic [COE_WDTH-1:0] rd_data
);

  logic [COE_WDTH-1:0] mem_q [COE_NUM_HALF];
  logic [COE_WDTH-1:0] mem_d [COE_NUM_HALF];
  logic [COE_WDTH-1:0] rd_data_q;
  logic [COE_WDTH-1:0] rd_data_d;

  // Write decode: the matching entry takes wr_data, all others hold.
  always_comb begin
    for (int i = 0; i < int'(COE_NUM_HALF); i++) begin
      if (wr_en && (wr_addr == 8'(i))) begin
        mem_d[i] = wr_data;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Read mux by compare rather than array index keeps the 8-bit address
  // legal for any entry count.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      for (int i = 0; i < int'(COE_NUM_HALF); i++) begin
        rd_data_d = (rd_addr == 8'(i)) ? mem_q[i] : rd_data_d;
      end
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Storage and read register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(COE_NUM_HALF); i++) begin
        mem_q[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      for (int i = 0; i < int'(COE_NUM_HALF); i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fir_coe_seq.sv
// -----------------------------------------------------------------------------
// fir_coe_seq
// Host-programmable coefficient shadow plus a sequencer that streams the
// stored symmetric coefficient set to a FIR reload stage, waits LOAD_GAP idle
// cycles, then issues a one-cycle coe_load commit followed by a done pulse.
// Optional feature macro: FIR_COE_CHKSUM_EN -- adds an expected-checksum
// register at CHK_ADDR; on mismatch the commit is withheld and err is set.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   host_wr_en/addr/data: host register write port
//   start               : request a stream+load sequence (IDLE only)
//   busy, done, err     : status (err is sticky, cleared by next start)
//   wr_drop             : pulse one cycle after a rejected host write
//   coe_vld/sop/din     : coefficient beat stream
//   coe_load            : commit pulse to the reload stage
//   coe_fir_dec         : decimation value captured at sequence start
// -----------------------------------------------------------------------------
module fir_coe_seq
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned COE_NUM      = 51,
  parameter int unsigned COE_WDTH     = 29,
  parameter int unsigned COE_NUM_HALF = (COE_NUM + 32'd1) / 32'd2,
  parameter int unsigned LOAD_GAP     = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                host_wr_en,
  input  logic [7:0]          host_wr_addr,
  input  logic [31:0]         host_wr_data,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                wr_drop,
  output logic                coe_vld,
  output logic                coe_sop,
  output logic [COE_WDTH-1:0] coe_din,
  output logic                coe_load,
  output logic [31:0]         coe_fir_dec
);

  // Half-set size must cover the full symmetric tap count; addresses above
  // it are reserved for DEC_ADDR/CHK_ADDR.
  if ((COE_NUM_HALF < 32'd1) || (COE_NUM_HALF > 32'd254) ||
      (LOAD_GAP < 32'd2) || (LOAD_GAP > 32'd15) ||
      ((32'd2 * COE_NUM_HALF) < COE_NUM)) begin : g_cfg_chk
    $error("fir_coe_seq: illegal parameter combination");
  end

  localparam logic [7:0] HALF_W   = 8'(COE_NUM_HALF);
  localparam logic [3:0] GAP_LAST = 4'(LOAD_GAP - 32'd1);

  fir_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  gap_q, gap_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        wr_drop_q, wr_drop_d;
  logic        coe_vld_q, coe_vld_d;
  logic        coe_sop_q, coe_sop_d;
  logic        coe_load_q, coe_load_d;
  logic [31:0] fir_dec_q, fir_dec_d;
  logic [31:0] dec_q, dec_d;

  logic        start_acc;
  logic        rd_en;
  logic        wr_ok;
  logic        addr_is_coe;
  logic        addr_mapped;
  logic        shadow_wr;

`ifdef FIR_COE_CHKSUM_EN
  logic [31:0] chk_q, chk_d;
  logic [31:0] sum_q, sum_d;
  logic        err_q, err_d;
`endif

  assign start_acc = (state_q == IDLE) && start;

  // Host write qualification. A write coinciding with an accepted start is
  // refused so the streamed set is exactly the pre-start contents.
  always_comb begin
    wr_ok       = host_wr_en && !busy_q && !start_acc;
    addr_is_coe = (host_wr_addr < HALF_W);
    addr_mapped = addr_is_coe || (host_wr_addr == DEC_ADDR);
`ifdef FIR_COE_CHKSUM_EN
    addr_mapped = addr_mapped || (host_wr_addr == CHK_ADDR);
`endif
    shadow_wr   = wr_ok && addr_is_coe;
    wr_drop_d   = host_wr_en && !(wr_ok && addr_mapped);
    if (wr_ok && (host_wr_addr == DEC_ADDR)) begin
      dec_d = host_wr_data;
    end else begin
      dec_d = dec_q;
    end
`ifdef FIR_COE_CHKSUM_EN
    if (wr_ok && (host_wr_addr == CHK_ADDR)) begin
      chk_d = host_wr_data;
    end else begin
      chk_d = chk_q;
    end
`endif
  end

  // Sequencer next state. cnt_q is the shadow read address: it is 0 in IDLE so
  // entry 0 is fetched on the start cycle, and runs one ahead during STREAM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    coe_vld_d  = 1'b0;
    coe_sop_d  = 1'b0;
    coe_load_d = 1'b0;
    fir_dec_d  = fir_dec_q;
    rd_en      = 1'b0;
`ifdef FIR_COE_CHKSUM_EN
    err_d = err_q;
    if (coe_vld_q) begin
      sum_d = sum_q + 32'(coe_din);
    end else begin
      sum_d = sum_q;
    end
`endif
    case (state_q)
      IDLE: begin
        if (start_acc) begin
          state_d   = STREAM;
          busy_d    = 1'b1;
          rd_en     = 1'b1;
          cnt_d     = 8'd1;
          coe_vld_d = 1'b1;
          coe_sop_d = 1'b1;
          fir_dec_d = dec_q;
`ifdef FIR_COE_CHKSUM_EN
          err_d = 1'b0;
          sum_d = 32'd0;
`endif
        end else begin
          busy_d = 1'b0;
        end
      end
      STREAM: begin
        if (cnt_q < HALF_W) begin
          rd_en     = 1'b1;
          cnt_d     = cnt_q + 8'd1;
          coe_vld_d = 1'b1;
        end else begin
          state_d = GAP;
          cnt_d   = 8'd0;
          gap_d   = GAP_LAST;
        end
      end
      GAP: begin
        if (gap_q == 4'd0) begin
`ifdef FIR_COE_CHKSUM_EN
          if (sum_q == chk_q) begin
            state_d    = LOAD;
            coe_load_d = 1'b1;
          end else begin
            // Bad set: withhold the commit but still report completion.
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
`else
          state_d    = LOAD;
          coe_load_d = 1'b1;
`endif
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      LOAD: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      gap_q      <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_drop_q  <= 1'b0;
      coe_vld_q  <= 1'b0;
      coe_sop_q  <= 1'b0;
      coe_load_q <= 1'b0;
      fir_dec_q  <= 32'd0;
      dec_q      <= 32'd0;
`ifdef FIR_COE_CHKSUM_EN
      chk_q      <= 32'd0;
      sum_q      <= 32'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_drop_q  <= wr_drop_d;
      coe_vld_q  <= coe_vld_d;
      coe_sop_q  <= coe_sop_d;
      coe_load_q <= coe_load_d;
      fir_dec_q  <= fir_dec_d;
      dec_q      <= dec_d;
`ifdef FIR_COE_CHKSUM_EN
      chk_q      <= chk_d;
      sum_q      <= sum_d;
      err_q      <= err_d;
`endif
    end
  end

  fir_coe_shadow #(
    .COE_WDTH     (COE_WDTH),
    .COE_NUM_HALF (COE_NUM_HALF)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (shadow_wr),
    .wr_addr (host_wr_addr),
    .wr_data (host_wr_data[COE_WDTH-1:0]),
    .rd_en   (rd_en),
    .rd_addr (cnt_q),
    .rd_data (coe_din)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign wr_drop     = wr_drop_q;
  assign coe_vld     = coe_vld_q;
  assign coe_sop     = coe_sop_q;
  assign coe_load    = coe_load_q;
  assign coe_fir_dec = fir_dec_q;
`ifdef FIR_COE_CHKSUM_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fir_coe_seq.sv
// Testbench for fir_coe_seq: directed scenarios plus random traffic, checked
// every cycle against a cycle-offset model of the sequence.
module tb_fir_coe_seq;

  localparam int H   = 26;
  localparam int G   = 4;
  localparam int SEQ = H + G + 2;

  localparam int K_MARK   = 1;
  localparam int K_27     = 2;
  localparam int K_ONE    = 3;
  localparam int K_B3     = 4;
  localparam int K_NOLOAD = 5;
  localparam int K_ZERO   = 6;
  localparam int K_CHKOK  = 7;
  localparam int K_CHKBAD = 8;
  localparam int K_ERRCLR = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_wr_en;
  logic [7:0]  host_wr_addr;
  logic [31:0] host_wr_data;
  logic        start;
  logic        busy, done, err, wr_drop, coe_vld, coe_sop, coe_load;
  logic [28:0] coe_din;
  logic [31:0] coe_fir_dec;

  always #5 clk = ~clk;

  fir_coe_seq dut (
    .clk          (clk),
    .rst          (rst),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .wr_drop      (wr_drop),
    .coe_vld      (coe_vld),
    .coe_sop      (coe_sop),
    .coe_din      (coe_din),
    .coe_load     (coe_load),
    .coe_fir_dec  (coe_fir_dec)
  );

  // ---------------- reference model ----------------
  // m_rel = cycles since the accepted start (0 = not in a sequence).
  logic [28:0] m_sh [H];
  logic [28:0] snap [H];
  logic [31:0] m_dec, m_chk, m_sum;
  int          m_rel, m_end;
  bit          m_pass;
  bit          e_busy, e_done, e_err, e_drop, e_vld, e_sop, e_load;
  logic [28:0] e_din;
  logic [31:0] e_dec;
  bit          chk_en = 1'b0;
  bit          idle, acc, mapped, ok;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < H; i++) m_sh[i] = '0;
      m_dec = 0; m_chk = 0; m_rel = 0; m_end = SEQ; m_pass = 1'b1;
      e_busy = 0; e_done = 0; e_err = 0; e_drop = 0; e_vld = 0;
      e_sop = 0; e_load = 0; e_din = '0; e_dec = 0;
    end else begin
      idle   = (m_rel == 0);
      acc    = start && idle;
      mapped = (int'(host_wr_addr) < H) || (host_wr_addr == 8'hFF);
`ifdef FIR_COE_CHKSUM_EN
      mapped = mapped || (host_wr_addr == 8'hFE);
`endif
      ok     = host_wr_en && idle && !acc && mapped;
      e_drop = host_wr_en && !ok;
      if (ok) begin
        if (int'(host_wr_addr) < H) m_sh[int'(host_wr_addr)] = host_wr_data[28:0];
        else if (host_wr_addr == 8'hFF) m_dec = host_wr_data;
        else m_chk = host_wr_data;
      end
      if (acc) begin
        snap  = m_sh;
        e_dec = m_dec;
        m_sum = 0;
        for (int i = 0; i < H; i++) m_sum = m_sum + 32'(m_sh[i]);
`ifdef FIR_COE_CHKSUM_EN
        m_pass = (m_sum == m_chk);
`else
        m_pass = 1'b1;
`endif
        m_end = m_pass ? SEQ : SEQ - 1;
        m_rel = 1;
        e_err = 0;
      end else if (m_rel != 0) begin
        m_rel = m_rel + 1;
        if (m_rel > m_end) m_rel = 0;
      end
      e_busy = (m_rel != 0);
      e_vld  = (m_rel >= 1) && (m_rel <= H);
      e_sop  = (m_rel == 1);
      if (e_vld) e_din = snap[m_rel-1];
      e_load = m_pass && (m_rel == H + G + 1);
      e_done = (m_rel != 0) && (m_rel == m_end);
      if (e_done && !m_pass) e_err = 1;
    end
    chk_en = 1'b1;
  end

  // ---------------- compare / monitor ----------------
  int      n_chk = 0, n_err = 0, cyc = 0;
  int      beats = 0, sops = 0, loads = 0, dones = 0, beat_idx = 0;
  longint  dsum = 0;
  int      last_beat_cyc = 0, load_cyc = 0, done_cyc = 0;
  int      b_beats = 0, b_sops = 0, b_loads = 0, b_dones = 0;
  longint  b_dsum = 0;
  logic [28:0] first_data = '0, beat3 = '0;
  int      lit_req = 0, lit_kind = 0, lit_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      chk("busy",    32'(busy),     32'(e_busy));
      chk("done",    32'(done),     32'(e_done));
      chk("err",     32'(err),      32'(e_err));
      chk("wr_drop", 32'(wr_drop),  32'(e_drop));
      chk("coe_vld", 32'(coe_vld),  32'(e_vld));
      chk("coe_sop", 32'(coe_sop),  32'(e_sop));
      chk("coe_load",32'(coe_load), 32'(e_load));
      chk("coe_din", 32'(coe_din),  32'(e_din));
      chk("coe_fir_dec", coe_fir_dec, e_dec);
      if (coe_vld) begin
        beats++; dsum += longint'(coe_din); last_beat_cyc = cyc;
        if (coe_sop) begin beat_idx = 0; first_data = coe_din; sops++; end
        else beat_idx++;
        if (beat_idx == 3) beat3 = coe_din;
      end
      if (coe_load) begin loads++; load_cyc = cyc; end
      if (done) begin dones++; done_cyc = cyc; end
    end
    if (lit_req != lit_seen) begin
      lit_seen = lit_req;
      case (lit_kind)
        K_MARK: begin
          b_beats = beats; b_sops = sops; b_loads = loads; b_dones = dones; b_dsum = dsum;
        end
        K_27: begin
          chk("set27_beats", 32'(beats - b_beats), 32'd26);
          chk("set27_sum", 32'(dsum - b_dsum), 32'd351);
          chk("set27_sops", 32'(sops - b_sops), 32'd1);
          chk("set27_first", 32'(first_data), 32'd1);
          chk("set27_loads", 32'(loads - b_loads), 32'd1);
          chk("set27_load_lat", 32'(load_cyc - last_beat_cyc), 32'd5);
          chk("set27_done_lat", 32'(done_cyc - load_cyc), 32'd1);
          chk("set27_dec", coe_fir_dec, 32'd8);
        end
        K_ONE: begin
          chk("restart_loads", 32'(loads - b_loads), 32'd1);
          chk("restart_dones", 32'(dones - b_dones), 32'd1);
        end
        K_B3: begin
          chk("entry3_kept", 32'(beat3), 32'd4);
          chk("entry3_beats", 32'(beats - b_beats), 32'd26);
        end
        K_NOLOAD: begin
          chk("rst_no_load", 32'(loads - b_loads), 32'd0);
          chk("rst_no_done", 32'(dones - b_dones), 32'd0);
        end
        K_ZERO: begin
          chk("zero_beats", 32'(beats - b_beats), 32'd26);
          chk("zero_sum", 32'(dsum - b_dsum), 32'd0);
          chk("zero_loads", 32'(loads - b_loads), 32'd1);
        end
        K_CHKOK: begin
          chk("chk_ok_load", 32'(loads - b_loads), 32'd1);
          chk("chk_ok_err", 32'(err), 32'd0);
        end
        K_CHKBAD: begin
          chk("chk_bad_load", 32'(loads - b_loads), 32'd0);
          chk("chk_bad_done", 32'(dones - b_dones), 32'd1);
          chk("chk_bad_err", 32'(err), 32'd1);
        end
        K_ERRCLR: chk("err_cleared", 32'(err), 32'd0);
        default: ;
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
    tick();
    host_wr_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic req(input int k);
    lit_kind = k;
    lit_req  = lit_req + 1;
    tick();
  endtask

  initial begin
    rst = 1'b1; host_wr_en = 1'b0; host_wr_addr = 8'd0; host_wr_data = 32'd0; start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Basic set: entries k+1, DEC = 8.
    for (int k = 0; k < H; k++) wr(8'(k), 32'(k + 1));
    wr(8'hFF, 32'd8);
    req(K_MARK);
    go();
    repeat (SEQ + 2) tick();
    req(K_27);

`ifdef FIR_COE_CHKSUM_EN
    wr(8'hFE, 32'd351);
    req(K_MARK);
    go();
    repeat (SEQ + 2) tick();
    req(K_CHKOK);
    wr(8'hFE, 32'd350);
    req(K_MARK);
    go();
    repeat (SEQ + 2) tick();
    req(K_CHKBAD);
    go();
    tick();
    req(K_ERRCLR);
    repeat (SEQ + 2) tick();
    wr(8'hFE, 32'd351);
`endif

    // Restart mid-stream is ignored; a write while busy is dropped.
    req(K_MARK);
    go();
    repeat (5) tick();
    start = 1'b1; tick(); start = 1'b0;
    wr(8'd3, 32'd99);
    repeat (SEQ) tick();
    req(K_ONE);
    req(K_MARK);
    go();
    repeat (SEQ + 2) tick();
    req(K_B3);

    // Unmapped addresses, and a write colliding with start.
    wr(8'd26, 32'd123);
    wr(8'h80, 32'd77);
    wr(8'hFE, 32'd351);
    host_wr_en = 1'b1; host_wr_addr = 8'd5; host_wr_data = 32'd555; start = 1'b1;
    tick();
    host_wr_en = 1'b0; start = 1'b0;
    repeat (SEQ + 2) tick();

    // Reset mid-stream, then a fresh start streams zeros.
    req(K_MARK);
    go();
    repeat (9) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (SEQ) tick();
    req(K_NOLOAD);
    req(K_MARK);
    go();
    repeat (SEQ + 2) tick();
    req(K_ZERO);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      int r;
      rst        = ($urandom_range(0, 199) == 0);
      start      = ($urandom_range(0, 24) == 0);
      host_wr_en = ($urandom_range(0, 2) == 0);
      r = int'($urandom_range(0, 9));
      if (r < 6)       host_wr_addr = 8'($urandom_range(0, 29));
      else if (r == 6) host_wr_addr = 8'hFF;
      else if (r == 7) host_wr_addr = 8'hFE;
      else if (r == 8) host_wr_addr = 8'h80;
      else             host_wr_addr = 8'($urandom);
      host_wr_data = $urandom;
      tick();
    end
    rst = 1'b0; start = 1'b0; host_wr_en = 1'b0;
    repeat (SEQ + 2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fir_coe_seq.md
FIR_COE_SEQ -- requirements
Module: fir_coe_seq

Interface
REQ-001 SHALL have parameter COE_NUM, default 51, meaning full FIR tap count.
REQ-002 SHALL have parameter COE_WDTH, default 29, meaning coefficient width in bits.
REQ-003 SHALL have parameter COE_NUM_HALF, default (COE_NUM+1)/2, meaning number of stored symmetric coefficients, legal range 1..254.
REQ-004 SHALL have parameter LOAD_GAP, default 4, meaning idle cycles between the last coefficient beat and coe_load, legal range 2..15.
REQ-005 SHALL have ports, in order:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- host_wr_en  in  1  host register write strobe.
- host_wr_addr  in  8  write address.
- host_wr_data  in  32  write data.
- start  in  1  request to stream and load the shadow set.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky checksum error.
- wr_drop  out  1  one-cycle pulse when a write is rejected.
- coe_vld  out  1  coefficient beat valid.
- coe_sop  out  1  first beat of a set.
- coe_din  out  COE_WDTH  coefficient data.
- coe_load  out  1  one-cycle commit pulse to the reload stage.
- coe_fir_dec  out  32  decimation value that accompanies the set.

Function
REQ-006 Writes with host_wr_addr < COE_NUM_HALF SHALL store host_wr_data[COE_WDTH-1:0] into shadow entry addr.
REQ-007 Writes to DEC_ADDR (8'hFF) SHALL update the dec shadow register.
REQ-008 A write SHALL be rejected, with wr_drop pulsed the next cycle, when busy=1 or the address is unmapped.
REQ-009 The FSM SHALL use states IDLE, STREAM, GAP, LOAD and DONE.
REQ-010 start is accepted only in IDLE; start in any other state SHALL be ignored with no queuing.
REQ-011 On start accepted at cycle T, the next state SHALL be STREAM.
- From T+1 to T+COE_NUM_HALF: coe_vld=1, with coe_din = entry k at T+1+k.
- coe_sop=1 only at T+1.
- Beats SHALL be contiguous, with no bubbles.
REQ-012 GAP SHALL hold coe_vld=coe_sop=0 for exactly LOAD_GAP cycles.
REQ-013 LOAD SHALL assert coe_load for one cycle, at T+COE_NUM_HALF+LOAD_GAP+1.
REQ-014 DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-015 busy SHALL be 1 from T+1 through the DONE cycle inclusive.
REQ-016 coe_fir_dec SHALL capture the dec shadow at T+1 and hold it stable until the next accepted start.
REQ-017 coe_din SHALL hold its last value when coe_vld=0.
REQ-018 A host write in the same cycle as an accepted start SHALL be rejected, because busy rises at T+1 and the write is evaluated against state at T; the streamed set SHALL reflect pre-start contents.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 rst SHALL force the FSM to IDLE from any state, including mid-STREAM, with no coe_load issued.
REQ-021 Under rst, busy, done, err, wr_drop, coe_vld, coe_sop and coe_load SHALL be 0.
REQ-022 Under rst, coe_din, coe_fir_dec, all shadow entries, the dec shadow and the checksum shadow SHALL be 0.

Configuration
REQ-023 With macro FIR_COE_CHKSUM_EN defined:
- Address CHK_ADDR (8'hFE) SHALL be writable as the expected checksum.
- During STREAM, a 32-bit modulo sum of the zero-extended coefficients SHALL be accumulated.
- On mismatch at the end of GAP, LOAD SHALL be skipped (coe_load stays 0), err SHALL be set, and done SHALL still pulse.
- err SHALL clear on the next accepted start.
REQ-024 Without FIR_COE_CHKSUM_EN:
- err SHALL be tied to 0.
- 8'hFE SHALL be unmapped, so writes to it cause wr_drop.
- coe_load SHALL always issue.

Structure
REQ-025 Package fir_ctrl_pkg SHALL hold DEC_ADDR, CHK_ADDR and the FSM state enum typedef.
REQ-026 Shadow storage SHALL be a sub-module named fir_coe_shadow, with a write port and a registered read port addressed by the FSM beat counter.

Verification
REQ-027 Write entries 0..25 = k+1 and DEC=8, then start -> 26 contiguous beats with data 1..26, sop on beat 1 only, coe_load 5 cycles after the last beat, done 1 cycle later, coe_fir_dec=8.
REQ-028 start pulsed again mid-STREAM -> ignored; exactly one coe_load; write at addr 3 while busy -> wr_drop, entry 3 unchanged.
REQ-029 Write to addr 26 and to 8'h80 -> wr_drop each; no shadow change.
REQ-030 rst asserted at beat 10 -> all outputs 0 next cycle, no coe_load; a fresh start after rst streams all zeros.
REQ-031 With FIR_COE_CHKSUM_EN, CHK=351 for the REQ-027 set -> coe_load issued and err=0; CHK=350 -> no coe_load, err=1, done pulses, err clears on the next start.
